// File: rtl/conv_accumulator_if.sv
// Valid/ready handshake bundle between the multiplier array, the accumulator and the output writer.
interface conv_accumulator_if #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned KERNEL_SIZE = 5
);
  localparam int unsigned N = KERNEL_SIZE * KERNEL_SIZE;

  logic                    in_valid;
  logic                    in_ready;
  logic [N*DATA_WIDTH-1:0] in_products;
  logic [DATA_WIDTH-1:0]   in_bias;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_WIDTH-1:0]   out_data;
  logic                    out_sat;

  modport master (
    output in_valid, in_products, in_bias, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_products, in_bias, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/conv_accumulator.sv
// Pipelined adder tree: sums a KERNEL_SIZE^2 product vector, adds the window bias and
// saturates back to DATA_WIDTH. One register per tree level plus input and output stages.
module conv_accumulator #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned FRAC_BIT    = 8,
  parameter int unsigned KERNEL_SIZE = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  conv_accumulator_if.slave   bus
);
  localparam int unsigned N      = KERNEL_SIZE * KERNEL_SIZE;
  localparam int unsigned LEVELS = $clog2(N);
  localparam int unsigned ACC_W  = DATA_WIDTH + LEVELS + 1;
  localparam int unsigned NP     = 2 * N;
  localparam int unsigned STAGES = LEVELS + 1;

  typedef logic signed [ACC_W-1:0] acc_t;

  localparam acc_t SAT_MAX = acc_t'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
  localparam acc_t SAT_MIN = acc_t'(-(64'sd1 <<< (DATA_WIDTH - 1)));

  // Terms are in a common Q format, so FRAC_BIT only constrains legal parameter sets.
  if (N < 2 || FRAC_BIT >= DATA_WIDTH) begin : g_bad_param
    $error("conv_accumulator: need KERNEL_SIZE^2 >= 2 and FRAC_BIT < DATA_WIDTH");
  end

  // Number of live elements at tree level k.
  function automatic int level_cnt(input int k);
    return (int'(N) + (1 << k) - 1) >> k;
  endfunction

  logic                  stall;
  acc_t                  tree_d [STAGES][NP];
  acc_t                  tree_q [STAGES][NP];
  logic [STAGES-1:0]     vld_q;
  logic [DATA_WIDTH-1:0] bias_q [STAGES];
  acc_t                  sum_c;
  logic [DATA_WIDTH-1:0] sat_data_c;
  logic                  sat_flag_c;

  assign stall        = bus.out_valid && !bus.out_ready;
  assign bus.in_ready = !stall;

  // Stage 0 sign-extends the products; stage s pairs (2j, 2j+1) of stage s-1, odd tail passes through.
  always_comb begin : tree_next
    for (int s = 0; s < int'(STAGES); s++) begin
      for (int j = 0; j < int'(NP); j++) begin
        tree_d[s][j] = '0;
      end
    end
    for (int i = 0; i < int'(N); i++) begin
      tree_d[0][i] = acc_t'($signed(bus.in_products[i*DATA_WIDTH +: DATA_WIDTH]));
    end
    for (int s = 1; s < int'(STAGES); s++) begin
      for (int j = 0; j < int'(N); j++) begin
        if (2*j + 1 < level_cnt(s - 1)) begin
          tree_d[s][j] = tree_q[s-1][2*j] + tree_q[s-1][2*j+1];
        end else if (2*j < level_cnt(s - 1)) begin
          tree_d[s][j] = tree_q[s-1][2*j];
        end
      end
    end
  end

  // Bias add and clip to the DATA_WIDTH signed range.
  always_comb begin : saturate
    sum_c      = tree_q[STAGES-1][0] + acc_t'($signed(bias_q[STAGES-1]));
    sat_flag_c = 1'b0;
    sat_data_c = DATA_WIDTH'(sum_c);
    if (sum_c > SAT_MAX) begin
      sat_data_c = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      sat_flag_c = 1'b1;
    end else if (sum_c < SAT_MIN) begin
      sat_data_c = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      sat_flag_c = 1'b1;
    end
  end

  // Whole pipeline, bubbles included, freezes while the output is stalled.
  always_ff @(posedge clk or negedge rst_n) begin : pipe_regs
    if (!rst_n) begin
      for (int s = 0; s < int'(STAGES); s++) begin
        for (int j = 0; j < int'(NP); j++) begin
          tree_q[s][j] <= '0;
        end
        bias_q[s] <= '0;
      end
      vld_q         <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sat   <= 1'b0;
    end else if (!stall) begin
      for (int s = 0; s < int'(STAGES); s++) begin
        for (int j = 0; j < int'(NP); j++) begin
          tree_q[s][j] <= tree_d[s][j];
        end
      end
      bias_q[0] <= bus.in_bias;
      for (int s = 1; s < int'(STAGES); s++) begin
        bias_q[s] <= bias_q[s-1];
      end
      vld_q         <= {vld_q[STAGES-2:0], bus.in_valid};
      bus.out_valid <= vld_q[STAGES-1];
      bus.out_data  <= sat_data_c;
      bus.out_sat   <= sat_flag_c;
    end
  end
endmodule

// File: tb/tb_conv_accumulator.sv
// Randomized bench for conv_accumulator against an arithmetic sum/bias/saturate reference.
module tb_conv_accumulator;
  localparam int unsigned DW  = 16;
  localparam int unsigned KS  = 5;
  localparam int unsigned N   = KS * KS;
  localparam int          LAT = 6;

  typedef logic [N*DW-1:0] win_t;
  typedef struct {
    logic [DW-1:0] data;
    logic          sat;
    int            acc_cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  conv_accumulator_if #(.DATA_WIDTH(DW), .KERNEL_SIZE(KS)) bus ();

  conv_accumulator #(.DATA_WIDTH(DW), .FRAC_BIT(8), .KERNEL_SIZE(KS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t          expq[$];
  int            n_checks   = 0;
  int            n_errors   = 0;
  int            cyc        = 0;
  bit            lat_chk    = 1'b0;
  bit            rand_ready = 1'b0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: plain integer sum of all products plus bias, clipped to 16-bit signed.
  function automatic exp_t model(input win_t p, input logic [DW-1:0] b);
    exp_t e;
    int   sum;
    sum = int'($signed(b));
    for (int i = 0; i < int'(N); i++) sum += int'($signed(p[i*DW +: DW]));
    e.acc_cyc = 0;
    if (sum > 32767) begin
      e.data = 16'h7FFF; e.sat = 1'b1;
    end else if (sum < -32768) begin
      e.data = 16'h8000; e.sat = 1'b1;
    end else begin
      e.data = DW'(sum); e.sat = 1'b0;
    end
    return e;
  endfunction

  function automatic win_t fill(input logic [DW-1:0] v);
    return {N{v}};
  endfunction

  function automatic win_t rand_window();
    win_t p;
    int   mode;
    mode = int'($urandom_range(0, 2));
    for (int i = 0; i < int'(N); i++) begin
      case (mode)
        0:       p[i*DW +: DW] = DW'($urandom);
        1:       p[i*DW +: DW] = DW'(int'($urandom_range(0, 1023)) - 512);
        default: p[i*DW +: DW] = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
      endcase
    end
    return p;
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: handshake rule, stall stability, ordered scoreboard, latency.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      check("in_ready", 32'(bus.in_ready), 32'(!(bus.out_valid && !bus.out_ready)));
      if (prev_stall) begin
        check("stall_hold_data", 32'(bus.out_data), 32'(prev_data));
        check("stall_hold_valid", 32'(bus.out_valid), 32'(1));
      end
      if (bus.in_valid && bus.in_ready) begin
        e = model(bus.in_products, bus.in_bias);
        e.acc_cyc = cyc;
        expq.push_back(e);
      end
      if (bus.out_valid) begin
        if (expq.size() == 0) begin
          check("spurious_out", 32'(1), 32'(0));
        end else if (bus.out_ready) begin
          e = expq.pop_front();
          check("out_data", 32'(bus.out_data), 32'(e.data));
          check("out_sat", 32'(bus.out_sat), 32'(e.sat));
          if (lat_chk) check("latency", 32'(cyc - (e.acc_cyc + 1)), 32'(LAT));
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
    end
  end

  task automatic send(input win_t p, input logic [DW-1:0] b);
    int t;
    bus.in_products = p;
    bus.in_bias     = b;
    bus.in_valid    = 1'b1;
    t = 0;
    @(negedge clk);
    while (!bus.in_ready) begin
      t++;
      if (t > 500) begin
        check("accept_timeout", 32'(0), 32'(1));
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && expq.size() != 0; t++) @(negedge clk);
    check("drain", 32'(expq.size()), 32'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    win_t          p;
    logic [DW-1:0] tmp;

    bus.in_valid    = 1'b0;
    bus.in_products = '0;
    bus.in_bias     = '0;
    bus.out_ready   = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'(0));
    check("rst_out_data", 32'(bus.out_data), 32'(0));
    check("rst_out_sat", 32'(bus.out_sat), 32'(0));
    check("rst_in_ready", 32'(bus.in_ready), 32'(1));
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    lat_chk = 1'b1;
    send(fill(16'h0100), 16'h0000);
    drain();

    send(fill(16'h7FFF), 16'h7FFF);
    send(fill(16'h8000), 16'h8000);
    drain();

    for (int i = 0; i < int'(N); i++) p[i*DW +: DW] = DW'((i - 12) * 256);
    send(p, 16'h0080);
    tmp = p[0 +: DW];
    p[0 +: DW] = p[24*DW +: DW];
    p[24*DW +: DW] = tmp;
    send(p, 16'h0080);
    drain();

    for (int k = 0; k < 20; k++) send(fill(DW'(k * 256)), 16'h0000);
    drain();

    lat_chk    = 1'b0;
    rand_ready = 1'b1;
    for (int w = 0; w < 300; w++) send(rand_window(), DW'($urandom));
    drain();
    rand_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset with one window at the output and four still in the tree.
    lat_chk = 1'b1;
    for (int w = 1; w <= 5; w++) send(fill(DW'(w * 16)), 16'h0005);
    @(posedge clk);
    @(posedge clk);
    #3;
    check("pre_rst_valid", 32'(bus.out_valid), 32'(1));
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus.out_valid), 32'(0));
    check("async_rst_data", 32'(bus.out_data), 32'(0));
    check("async_rst_sat", 32'(bus.out_sat), 32'(0));
    check("async_rst_in_ready", 32'(bus.in_ready), 32'(1));
    expq.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      check("no_stale_out", 32'(bus.out_valid), 32'(0));
    end
    @(posedge clk);
    #1;
    send(fill(16'h0040), 16'h0010);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/conv_accumulator.md
# conv_accumulator

Pipelined reduction stage that consumes the KERNEL_SIZE² fixed-point product vector produced by the convolver's multiplier array. It sums all products, adds a per-kernel bias and saturates the result back to DATA_WIDTH, producing one convolution output pixel per accepted window. Transfers on both sides use a valid/ready handshake so the block can sit between the multiplier array and the output writer.

## Interface

- DATA_WIDTH, 16, width of each product, the bias and the output; signed two's complement
- FRAC_BIT, 8, fractional bits; products, bias and output share the same Q format
- KERNEL_SIZE, 5, kernel edge; N = KERNEL_SIZE² products per window
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  in_products and in_bias are valid
- in_ready  output  1  block accepts input this cycle
- in_products  input  N*DATA_WIDTH  signed products; product i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- in_bias  input  DATA_WIDTH  signed bias for this window
- out_valid  output  1  out_data is valid
- out_ready  input  1  downstream accepts out_data
- out_data  output  DATA_WIDTH  saturated sum + bias
- out_sat  output  1  out_data was clipped; qualified by out_valid

## Operation

- Accept when in_valid && in_ready; the bias travels with its product vector.
- Define LEVELS = ceil(log2(N)); N=25 gives LEVELS=5. LEVELS must be at least 1, so N ≥ 2.
- Internal width is ACC_W = DATA_WIDTH + LEVELS + 1. All operands are sign-extended to ACC_W, so no intermediate overflow is possible.
- Tree level k adds adjacent pairs from level k-1, with element 2j paired with 2j+1.
  - An unpaired last element passes through unchanged and is registered with the sums.
  - Each level is one register stage.
- Bias is carried alongside the tree in a delay line with matching depth.
- Final stage computes sum + bias, then saturates to DATA_WIDTH:
  - If the value is greater than 2^(DATA_WIDTH-1)-1, output 0x7FFF (for 16 bits) and set out_sat=1.
  - If the value is less than -2^(DATA_WIDTH-1), output 0x8000 and set out_sat=1.
  - Otherwise output the low DATA_WIDTH bits and set out_sat=0.
- No rescaling occurs, because all terms are already in the same Q format.
- A valid bit travels with every stage.
- Stall rule: stall = out_valid && !out_ready.
  - While stall is high, every stage, including the valid bits, holds its value.
  - in_ready = !stall, which is combinational from out_valid and out_ready.
  - Bubbles are not compressed. An empty stage also freezes during a stall.
- While stall is low, every stage advances, so the pipeline can accept one window per cycle.
- Output order equals input order. No window is dropped or duplicated.

## Timing

- Latency L = LEVELS + 1 cycles; L = 6 for the defaults.
- A window accepted at edge t appears with out_valid=1 after edge t+L when no stall occurs. Each stalled cycle adds exactly one cycle.
- Sustained throughput is 1 window per cycle when out_ready is held at 1.
- out_data, out_sat and out_valid are registered outputs. in_ready is the only combinational output.
- Reset asserted at any time, including mid-operation:
  - All valid bits clear immediately and in-flight windows are discarded.
  - out_valid=0, out_data=0, out_sat=0.
  - in_ready=1 while in reset.
- After rst_n deasserts, the first accept can occur on the next rising edge.
- When in_valid and stall are both high, no accept takes place and upstream must hold its data.
- When the output is consumed in the same cycle that a new window is accepted, both transfers complete. Nothing is lost.

## Test plan

- **Basic sum:** DATA_WIDTH=16, FRAC_BIT=8; all 25 products=0x0100, bias=0x0000, out_ready=1 → out_data=0x1900, out_sat=0, out_valid exactly 6 cycles after the accept.
- **Positive saturation:** all products 0x7FFF, bias 0x7FFF → out_data=0x7FFF, out_sat=1. **Negative saturation:** all products 0x8000, bias 0x8000 → out_data=0x8000, out_sat=1.
- **Mixed signs:** product i = (i-12)<<8 for i=0..24, bias 0x0080 → out_data=0x0080, out_sat=0. Swapping products 0 and 24 gives the same result.
- **Streaming:** 20 back-to-back windows, window k all products=k<<8, bias=0 → outputs 25k<<8 (clipped above 0x7FFF, so k≥6 gives 0x7FFF with out_sat=1), in order, at one per cycle.
- **Backpressure:** random out_ready (50%) while upstream drives continuously → in_ready low exactly when out_valid && !out_ready, out_data stable while stalled, and the output sequence matches the golden model with no loss or duplication.
- **Reset mid-flight:** assert rst_n=0 with 4 windows in flight → out_valid=0 and out_data=0 asynchronously. After release, no stale outputs appear, and a new window produces its correct result at latency 6.
